// File: rtl/l8_pkt_arbiter2.sv
`default_nettype none
// l8_pkt_arbiter2 - packet-granular round-robin 2:1 merge of l8 Avalon-ST sources,
// beat-count watchdog truncation, one registered output stage.  Rev 1.0
module l8_pkt_arbiter2 #(
  parameter logic [15:0] MAX_PKT_BEATS = 16'd1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [63:0] in0_data,
  input  logic        in0_startofpacket,
  input  logic        in0_endofpacket,
  input  logic [2:0]  in0_empty,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [63:0] in1_data,
  input  logic        in1_startofpacket,
  input  logic        in1_endofpacket,
  input  logic [2:0]  in1_empty,
  input  logic        in1_valid,
  output logic        in1_ready,
  output logic [63:0] out_data,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [2:0]  out_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  grant,
  output logic        err_trunc,
  output logic        err_nosop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last_grant, last_grant_nx;
  logic [15:0] beat_cnt, beat_cnt_nx;

  logic        load_en;
  logic        req0, req1;
  logic        take_beat;
  logic        trunc_now;
  logic        nosop_now;

  logic [63:0] sel_data;
  logic        sel_sop;
  logic        sel_eop;
  logic [2:0]  sel_empty;
  logic        sel_valid;

  assign load_en   = !out_valid || out_ready;
  assign req0      = in0_valid && in0_startofpacket;
  assign req1      = in1_valid && in1_startofpacket;

  assign sel_data  = owner ? in1_data          : in0_data;
  assign sel_sop   = owner ? in1_startofpacket : in0_startofpacket;
  assign sel_eop   = owner ? in1_endofpacket   : in0_endofpacket;
  assign sel_empty = owner ? in1_empty         : in0_empty;
  assign sel_valid = owner ? in1_valid         : in0_valid;

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    beat_cnt_nx   = beat_cnt;
    in0_ready     = 1'b0;
    in1_ready     = 1'b0;
    take_beat     = 1'b0;
    trunc_now     = 1'b0;
    nosop_now     = 1'b0;

    case (state)
      IDLE: begin
        // Orphan beats are swallowed here so a stuck source cannot block arbitration.
        if (in0_valid && !in0_startofpacket) begin
          in0_ready = 1'b1;
          nosop_now = 1'b1;
        end else if (in1_valid && !in1_startofpacket) begin
          in1_ready = 1'b1;
          nosop_now = 1'b1;
        end

        if (req0 && req1) begin
          owner_nx = ~last_grant;
          state_nx = PASS;
        end else if (req0) begin
          owner_nx = 1'b0;
          state_nx = PASS;
        end else if (req1) begin
          owner_nx = 1'b1;
          state_nx = PASS;
        end
      end

      PASS: begin
        in0_ready = !owner && load_en;
        in1_ready =  owner && load_en;
        if (sel_valid && load_en) begin
          take_beat = 1'b1;
          if (sel_eop) begin
            state_nx      = IDLE;
            last_grant_nx = owner;
            beat_cnt_nx   = 16'd0;
          end else if (beat_cnt == MAX_PKT_BEATS - 16'd1) begin
            trunc_now = 1'b1;
            state_nx  = DROP;
          end else begin
            beat_cnt_nx = beat_cnt + 16'd1;
          end
        end
      end

      DROP: begin
        // Drain the runaway packet without touching the output register.
        in0_ready = !owner;
        in1_ready =  owner;
        if (sel_valid && sel_eop) begin
          state_nx      = IDLE;
          last_grant_nx = owner;
          beat_cnt_nx   = 16'd0;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state             <= IDLE;
      owner             <= 1'b0;
      last_grant        <= 1'b1;
      beat_cnt          <= 16'd0;
      grant             <= 2'b00;
      err_trunc         <= 1'b0;
      err_nosop         <= 1'b0;
      out_data          <= 64'd0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= 3'd0;
      out_valid         <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      beat_cnt   <= beat_cnt_nx;
      grant      <= (state_nx == IDLE) ? 2'b00 : (owner_nx ? 2'b10 : 2'b01);
      err_trunc  <= trunc_now;
      err_nosop  <= nosop_now;
      if (load_en) begin
        out_valid <= take_beat;
        if (take_beat) begin
          out_data          <= sel_data;
          out_startofpacket <= sel_sop;
          out_endofpacket   <= sel_eop || trunc_now;
          out_empty         <= trunc_now ? 3'd0 : sel_empty;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l8_pkt_arbiter2.sv
`default_nettype none
// tb_l8_pkt_arbiter2 - randomized self-checking bench; expected output comes from a
// packet-level model of the arbitration, truncation and orphan-discard rules.
module tb_l8_pkt_arbiter2;

  localparam int MAXB = 8;

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  emp;
  } beat_t;

  typedef struct {
    beat_t       b;
    int unsigned gap;
  } item_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [63:0] d0 = '0, d1 = '0;
  logic        s0 = 1'b0, s1 = 1'b0, e0 = 1'b0, e1 = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic [2:0]  m0 = '0, m1 = '0;
  logic        r0, r1;
  logic [63:0] od;
  logic        osop, oeop, ov;
  logic [2:0]  oemp;
  logic        ordy = 1'b1;
  logic [1:0]  grant;
  logic        etr, ens;

  item_t q0[$], q1[$];
  beat_t mq0[$], mq1[$];
  beat_t exp_q[$], got[$];
  int    total = 0, bad = 0;
  int    ntrunc = 0, nnosop = 0, exp_trunc = 0;
  int    ordy_mode = 0;
  bit    model_last = 1'b1;

  always #5 clk = ~clk;

  l8_pkt_arbiter2 #(.MAX_PKT_BEATS(16'(MAXB))) dut (
    .clk(clk), .arst_n(arst_n),
    .in0_data(d0), .in0_startofpacket(s0), .in0_endofpacket(e0), .in0_empty(m0),
    .in0_valid(v0), .in0_ready(r0),
    .in1_data(d1), .in1_startofpacket(s1), .in1_endofpacket(e1), .in1_empty(m1),
    .in1_valid(v1), .in1_ready(r1),
    .out_data(od), .out_startofpacket(osop), .out_endofpacket(oeop), .out_empty(oemp),
    .out_valid(ov), .out_ready(ordy),
    .grant(grant), .err_trunc(etr), .err_nosop(ens)
  );

  // Source 0 driver: presents queue head, pops it once a handshake is seen.
  initial begin : drv0
    bit acc;
    int unsigned gapc;
    gapc = 0;
    forever begin
      @(negedge clk);
      acc = v0 && r0;
      @(posedge clk);
      #1;
      if (acc && q0.size() > 0) begin
        void'(q0.pop_front());
        if (q0.size() > 0) gapc = q0[0].gap;
      end
      if (q0.size() > 0 && gapc == 0) begin
        {d0, s0, e0, m0} = q0[0].b;
        v0 = 1'b1;
      end else begin
        v0 = 1'b0;
        if (gapc > 0) gapc--;
      end
    end
  end

  initial begin : drv1
    bit acc;
    int unsigned gapc;
    gapc = 0;
    forever begin
      @(negedge clk);
      acc = v1 && r1;
      @(posedge clk);
      #1;
      if (acc && q1.size() > 0) begin
        void'(q1.pop_front());
        if (q1.size() > 0) gapc = q1[0].gap;
      end
      if (q1.size() > 0 && gapc == 0) begin
        {d1, s1, e1, m1} = q1[0].b;
        v1 = 1'b1;
      end else begin
        v1 = 1'b0;
        if (gapc > 0) gapc--;
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       ordy = 1'b1;
        1:       ordy = ~ordy;
        2:       ordy = ($urandom_range(0, 3) != 0);
        default: ordy = 1'b0;
      endcase
    end
  end

  // Output monitor: collects accepted beats, counts error pulses, checks stall stability.
  initial begin : mon
    bit    pstall;
    beat_t pb;
    pstall = 1'b0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          total++;
          if (ov !== 1'b1 || {od, osop, oeop, oemp} !== pb) begin
            bad++;
            $display("FAIL stall_hold: got v=%0b beat=%h required v=1 beat=%h", ov, {od, osop, oeop, oemp}, pb);
          end
        end
        if (etr) ntrunc++;
        if (ens) nnosop++;
        if (ov && ordy) got.push_back({od, osop, oeop, oemp});
        pstall = ov && !ordy;
        pb = {od, osop, oeop, oemp};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "global timeout");
  end

  task automatic apply_reset();
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    arst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic push_pkt(input int s, input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      item_t it;
      it.b.d         = {32'($urandom), 32'($urandom)};
      it.b.d[63:60]  = 4'(s);
      it.b.sop       = (i == 0);
      it.b.eop       = (i == len - 1);
      it.b.emp       = 3'($urandom);
      it.gap         = (gaps && i > 0) ? $urandom_range(0, 2) : 0;
      if (s == 0) begin
        q0.push_back(it);
        mq0.push_back(it.b);
      end else begin
        q1.push_back(it);
        mq1.push_back(it.b);
      end
    end
  endtask

  // Packet-level model: alternate when both sources hold packets, keep at most
  // MAXB beats per packet, and close a cut packet with eop=1/empty=0.
  task automatic predict();
    while (mq0.size() > 0 || mq1.size() > 0) begin
      int    s;
      int    n;
      bit    fin;
      beat_t b;
      if (mq0.size() > 0 && mq1.size() > 0) s = model_last ? 0 : 1;
      else s = (mq0.size() > 0) ? 0 : 1;
      n = 0;
      fin = 1'b0;
      while (!fin) begin
        b = (s == 0) ? mq0.pop_front() : mq1.pop_front();
        fin = b.eop;
        if (n == MAXB - 1 && !b.eop) begin
          b.eop = 1'b1;
          b.emp = 3'd0;
          exp_q.push_back(b);
          exp_trunc++;
        end else if (n < MAXB) begin
          exp_q.push_back(b);
        end
        n++;
      end
      model_last = (s == 1);
    end
  endtask

  task automatic wait_drain(output bit to);
    int idle;
    idle = 0;
    for (int c = 0; c < 5000 && idle < 3; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !v0 && !v1 && !ov && grant == 2'b00) idle++;
      else idle = 0;
    end
    to = (idle < 3);
  endtask

  task automatic start_scn();
    @(negedge clk);
    got.delete();
    exp_q.delete();
    exp_trunc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if (ov !== 1'b0 || osop !== 1'b0 || oeop !== 1'b0) begin
      bad++; $display("FAIL reset_out_ctrl: got v/sop/eop=%b%b%b required 000", ov, osop, oeop);
    end
    total++;
    if (od !== 64'd0 || oemp !== 3'd0) begin
      bad++; $display("FAIL reset_out_data: got %h/%0d required 0/0", od, oemp);
    end
    total++;
    if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b required 00", grant); end
    total++;
    if ({etr, ens, r0, r1} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got trunc/nosop/rdy0/rdy1=%b required 0000", {etr, ens, r0, r1});
    end
  endtask

  task automatic test_single();
    int lat;
    bit to;
    ordy_mode = 0;
    start_scn();
    push_pkt(0, 3, 1'b0);
    predict();
    lat = 0;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 3) begin bad++; $display("FAIL single_latency: got %0d negedges required 3", lat); end
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL single_grant_busy: got %b required 01", grant); end
    wait_drain(to);
    total++;
    if (grant !== 2'b00) begin bad++; $display("FAIL single_grant_idle: got %b required 00", grant); end
    total++;
    if (to || got.size() != exp_q.size()) begin
      bad++; $display("FAIL single_count: got %0d beats (timeout=%0b) required %0d", got.size(), to, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL single_beat%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_tie();
    bit to;
    apply_reset();
    ordy_mode = 0;
    start_scn();
    for (int k = 0; k < 2; k++) begin
      push_pkt(0, $urandom_range(1, 5), 1'b0);
      push_pkt(1, $urandom_range(1, 5), 1'b0);
    end
    predict();
    wait_drain(to);
    total++;
    if (to || got.size() != exp_q.size()) begin
      bad++; $display("FAIL tie_count: got %0d beats (timeout=%0b) required %0d", got.size(), to, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL tie_beat%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int t0;
    ordy_mode = 1;
    start_scn();
    t0 = ntrunc;
    push_pkt(0, MAXB, 1'b0);
    predict();
    wait_drain(to);
    total++;
    if (to || got.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_count: got %0d beats (timeout=%0b) required %0d", got.size(), to, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
    total++;
    if (ntrunc - t0 != 0) begin bad++; $display("FAIL bp_no_trunc: got %0d pulses required 0", ntrunc - t0); end
    ordy_mode = 0;
  endtask

  task automatic test_trunc();
    bit to1, to2;
    int t0;
    ordy_mode = 0;
    start_scn();
    t0 = ntrunc;
    push_pkt(1, MAXB + 2, 1'b0);
    predict();
    wait_drain(to1);
    push_pkt(0, 3, 1'b0);
    predict();
    wait_drain(to2);
    total++;
    if (to1 || to2 || got.size() != exp_q.size()) begin
      bad++; $display("FAIL trunc_count: got %0d beats (timeout=%0b) required %0d", got.size(), to1 | to2, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL trunc_beat%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
    total++;
    if (ntrunc - t0 != 1) begin bad++; $display("FAIL trunc_pulse: got %0d pulses required 1", ntrunc - t0); end
  endtask

  task automatic test_orphan();
    item_t it;
    bit to;
    int n0;
    ordy_mode = 0;
    start_scn();
    n0 = nnosop;
    it.b.d = {32'($urandom), 32'($urandom)};
    it.b.sop = 1'b0;
    it.b.eop = 1'b1;
    it.b.emp = 3'd2;
    it.gap = 0;
    q0.push_back(it);
    @(negedge clk);
    total++;
    if (v0 !== 1'b1 || r0 !== 1'b1) begin
      bad++; $display("FAIL orphan_ready: got valid/ready=%b%b required 11", v0, r0);
    end
    wait_drain(to);
    total++;
    if (to || got.size() != 0) begin
      bad++; $display("FAIL orphan_out: got %0d beats (timeout=%0b) required 0", got.size(), to);
    end
    total++;
    if (nnosop - n0 != 1) begin bad++; $display("FAIL orphan_pulse: got %0d pulses required 1", nnosop - n0); end
  endtask

  task automatic test_random();
    bit to;
    int t0;
    ordy_mode = 2;
    for (int round = 0; round < 6; round++) begin
      start_scn();
      t0 = ntrunc;
      for (int k = $urandom_range(0, 3); k > 0; k--) push_pkt(0, $urandom_range(1, MAXB + 3), 1'b1);
      for (int k = $urandom_range(1, 3); k > 0; k--) push_pkt(1, $urandom_range(1, MAXB + 3), 1'b1);
      predict();
      wait_drain(to);
      total++;
      if (to || got.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count: got %0d beats (timeout=%0b) required %0d", round, got.size(), to, exp_q.size());
      end
      foreach (exp_q[i]) if (i < got.size()) begin
        total++;
        if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_beat%0d: got %h required %h", round, i, got[i], exp_q[i]); end
      end
      total++;
      if (ntrunc - t0 != exp_trunc) begin
        bad++; $display("FAIL rand%0d_trunc: got %0d pulses required %0d", round, ntrunc - t0, exp_trunc);
      end
    end
    ordy_mode = 0;
  endtask

  task automatic test_async_reset();
    bit to;
    int w;
    ordy_mode = 3;
    start_scn();
    push_pkt(0, 6, 1'b0);
    w = 0;
    while (!ov && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (ov !== 1'b1) begin bad++; $display("FAIL arst_setup: got out_valid=%b required 1", ov); end
    #2;
    arst_n = 1'b0;
    q0.delete();
    mq0.delete();
    #1;
    total++;
    if ({ov, osop, oeop, etr, ens} !== 5'b00000 || grant !== 2'b00 || od !== 64'd0) begin
      bad++; $display("FAIL arst_outputs: got v/sop/eop/tr/ns=%b grant=%b data=%h required all 0",
                      {ov, osop, oeop, etr, ens}, grant, od);
    end
    repeat (3) @(posedge clk);
    #2;
    arst_n = 1'b1;
    model_last = 1'b1;
    ordy_mode = 0;
    start_scn();
    push_pkt(1, 4, 1'b0);
    predict();
    wait_drain(to);
    total++;
    if (to || got.size() != exp_q.size()) begin
      bad++; $display("FAIL arst_after_count: got %0d beats (timeout=%0b) required %0d", got.size(), to, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL arst_after_beat%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_trunc();
    test_orphan();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
